// File: rtl/hilo_ctrl.sv
// hilo_ctrl: issue/commit controller between the execute stage and div_mul.
// Owns architectural HI/LO, decodes HI/LO-class ops into div_mul controls,
// holds operands stable while div_mul runs, commits results and stalls the
// pipeline until the unit is done. Handles MT/MF ops, flush and a watchdog.
module hilo_ctrl #(
  parameter int N       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_flush,
  input  logic         i_op_valid,
  input  logic [3:0]   i_op_code,
  input  logic [N-1:0] i_op_a,
  input  logic [N-1:0] i_op_b,
  output logic         o_op_ready,
  output logic         o_stall,
  output logic [N-1:0] o_mf_data,
  output logic         o_mf_valid,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo,
  output logic         o_err_timeout,
  output logic         o_dm_mul,
  output logic         o_dm_div,
  output logic         o_dm_using_sign,
  output logic         o_dm_add,
  output logic         o_dm_sub,
  output logic [N-1:0] o_dm_a,
  output logic [N-1:0] o_dm_b,
  output logic [N-1:0] o_dm_hi_in,
  output logic [N-1:0] o_dm_lo_in,
  output logic         o_dm_clear,
  output logic         o_dm_hold_result,
  input  logic [N-1:0] i_dm_hi_out,
  input  logic [N-1:0] i_dm_lo_out,
  input  logic         i_dm_write_hi_lo,
  input  logic         i_dm_waiting_result
);

  // Watchdog width leaves headroom above TIMEOUT-1 so the compare is exact.
  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  localparam logic [3:0] OP_MTHI = 4'd9;
  localparam logic [3:0] OP_MTLO = 4'd10;
  localparam logic [3:0] OP_MFHI = 4'd11;
  localparam logic [3:0] OP_MFLO = 4'd12;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Op-class decode helpers.
  function automatic logic f_is_arith(input logic [3:0] c);
    return (c >= 4'd1) && (c <= 4'd8);
  endfunction

  function automatic logic f_is_mul(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || ((c >= 4'd5) && (c <= 4'd8));
  endfunction

  function automatic logic f_is_div(input logic [3:0] c);
    return (c == 4'd3) || (c == 4'd4);
  endfunction

  function automatic logic f_is_add(input logic [3:0] c);
    return (c == 4'd5) || (c == 4'd6);
  endfunction

  function automatic logic f_is_sub(input logic [3:0] c);
    return (c == 4'd7) || (c == 4'd8);
  endfunction

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_hi;
  logic [N-1:0]  r_lo;
  logic          r_err_timeout;
  logic          r_dm_mul;
  logic          r_dm_div;
  logic          r_dm_using_sign;
  logic          r_dm_add;
  logic          r_dm_sub;
  logic [N-1:0]  r_dm_a;
  logic [N-1:0]  r_dm_b;
  logic [CW-1:0] r_wdog;

  logic          w_op_ready;
  logic          w_accept;
  logic          w_commit;
  logic          w_abort;
  logic          w_timeout;
  logic          w_mthi;
  logic          w_mtlo;
  logic          w_mf_valid;
  logic [N-1:0]  w_mf_data;
  logic          w_unused;

  // div_mul busy is implied by RUN; the input is kept for interface completeness.
  assign w_unused = i_dm_waiting_result;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control decode; flush outranks a result, a result outranks the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_op_ready  = 1'b0;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_timeout   = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    w_mf_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_op_ready = 1'b1;
        if (i_op_valid && !i_flush) begin
          if (f_is_arith(i_op_code)) begin
            w_accept    = 1'b1;
            w_state_nxt = S_RUN;
          end else if (i_op_code == OP_MTHI) begin
            w_mthi = 1'b1;
          end else if (i_op_code == OP_MTLO) begin
            w_mtlo = 1'b1;
          end else if ((i_op_code == OP_MFHI) || (i_op_code == OP_MFLO)) begin
            w_mf_valid = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (i_flush) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (i_dm_write_hi_lo) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == WD_LAST) begin
          w_abort     = 1'b1;
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // MF read path sees the pre-edge HI/LO, so an MT in the previous cycle is visible.
  always_comb begin
    w_mf_data = r_lo;
    if (i_op_code == OP_MFHI) begin
      w_mf_data = r_hi;
    end else begin
      w_mf_data = r_lo;
    end
  end

  // div_mul controls and operands: loaded on accept, held through RUN, controls dropped on exit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dm_mul        <= 1'b0;
      r_dm_div        <= 1'b0;
      r_dm_using_sign <= 1'b0;
      r_dm_add        <= 1'b0;
      r_dm_sub        <= 1'b0;
      r_dm_a          <= '0;
      r_dm_b          <= '0;
    end else if (w_accept) begin
      r_dm_mul        <= f_is_mul(i_op_code);
      r_dm_div        <= f_is_div(i_op_code);
      r_dm_using_sign <= i_op_code[0];
      r_dm_add        <= f_is_add(i_op_code);
      r_dm_sub        <= f_is_sub(i_op_code);
      r_dm_a          <= i_op_a;
      r_dm_b          <= i_op_b;
    end else if (w_commit || w_abort) begin
      r_dm_mul        <= 1'b0;
      r_dm_div        <= 1'b0;
      r_dm_using_sign <= 1'b0;
      r_dm_add        <= 1'b0;
      r_dm_sub        <= 1'b0;
    end
  end

  // Watchdog: cleared on accept, counts every RUN cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wdog <= '0;
    end else if (w_accept) begin
      r_wdog <= '0;
    end else if (r_state == S_RUN) begin
      r_wdog <= r_wdog + CW'(1);
    end
  end

  // Architectural HI/LO: written by a div_mul commit or by MTHI/MTLO.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= i_dm_hi_out;
      r_lo <= i_dm_lo_out;
    end else begin
      if (w_mthi) begin
        r_hi <= i_op_a;
      end
      if (w_mtlo) begin
        r_lo <= i_op_a;
      end
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end
  end

  assign o_op_ready       = w_op_ready;
  assign o_stall          = i_op_valid & ~w_op_ready;
  assign o_mf_data        = w_mf_data;
  assign o_mf_valid       = w_mf_valid;
  assign o_hi             = r_hi;
  assign o_lo             = r_lo;
  assign o_err_timeout    = r_err_timeout;
  assign o_dm_mul         = r_dm_mul;
  assign o_dm_div         = r_dm_div;
  assign o_dm_using_sign  = r_dm_using_sign;
  assign o_dm_add         = r_dm_add;
  assign o_dm_sub         = r_dm_sub;
  assign o_dm_a           = r_dm_a;
  assign o_dm_b           = r_dm_b;
  assign o_dm_hi_in       = r_hi;
  assign o_dm_lo_in       = r_lo;
  assign o_dm_clear       = w_abort;
  assign o_dm_hold_result = 1'b0;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl with a behavioural div_mul stub.
module tb_hilo_ctrl;

  localparam int N       = 32;
  localparam int TIMEOUT = 64;

  localparam int K_COMMIT = 0;
  localparam int K_MF     = 1;
  localparam int K_ABORT  = 2;

  typedef struct {
    int          kind;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
  } exp_t;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        flush    = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  op_code  = 4'd0;
  logic [31:0] op_a     = 32'd0;
  logic [31:0] op_b     = 32'd0;

  logic        o_op_ready, o_stall, o_mf_valid, o_err_timeout;
  logic [31:0] o_mf_data, o_hi, o_lo, o_dm_a, o_dm_b, o_dm_hi_in, o_dm_lo_in;
  logic        o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub;
  logic        o_dm_clear, o_dm_hold_result;

  logic        stub_wr   = 1'b0;
  logic        stub_busy = 1'b0;
  logic        stub_en   = 1'b1;
  int          stub_lat  = 6;
  int          stub_cnt  = 0;
  logic [31:0] stub_hi   = 32'd0;
  logic [31:0] stub_lo   = 32'd0;
  logic        stub_waiting;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  hilo_ctrl #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(reset), .i_flush(flush),
    .i_op_valid(op_valid), .i_op_code(op_code), .i_op_a(op_a), .i_op_b(op_b),
    .o_op_ready(o_op_ready), .o_stall(o_stall),
    .o_mf_data(o_mf_data), .o_mf_valid(o_mf_valid),
    .o_hi(o_hi), .o_lo(o_lo), .o_err_timeout(o_err_timeout),
    .o_dm_mul(o_dm_mul), .o_dm_div(o_dm_div), .o_dm_using_sign(o_dm_using_sign),
    .o_dm_add(o_dm_add), .o_dm_sub(o_dm_sub),
    .o_dm_a(o_dm_a), .o_dm_b(o_dm_b), .o_dm_hi_in(o_dm_hi_in), .o_dm_lo_in(o_dm_lo_in),
    .o_dm_clear(o_dm_clear), .o_dm_hold_result(o_dm_hold_result),
    .i_dm_hi_out(stub_hi), .i_dm_lo_out(stub_lo),
    .i_dm_write_hi_lo(stub_wr), .i_dm_waiting_result(stub_waiting)
  );

  always #5 clk = ~clk;

  assign stub_waiting = stub_busy;

  // Reference div_mul arithmetic: returns {hi, lo}.
  function automatic logic [63:0] dm_model(input logic mul, input logic sgn, input logic add,
                                           input logic sub, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0]        ae, be, p, acc;
    logic signed [31:0] sa, sb;
    logic [31:0]        q, r;
    acc = {hi, lo};
    if (mul) begin
      ae = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      be = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      p  = ae * be;
      if (add)      return acc + p;
      else if (sub) return acc - p;
      else          return p;
    end
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      sa = a; sb = b;
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // div_mul stub: starts when mul/div is seen, answers after stub_lat cycles unless disabled.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      stub_busy <= 1'b0;
      stub_wr   <= 1'b0;
      stub_cnt  <= 0;
    end else begin
      stub_wr <= 1'b0;
      if (o_dm_clear) begin
        stub_busy <= 1'b0;
      end else if (!stub_busy && !stub_wr && (o_dm_mul || o_dm_div)) begin
        stub_busy <= 1'b1;
        stub_cnt  <= stub_lat;
      end else if (stub_busy) begin
        if (stub_cnt == 0) begin
          if (stub_en) begin
            {stub_hi, stub_lo} <= dm_model(o_dm_mul, o_dm_using_sign, o_dm_add, o_dm_sub,
                                           o_dm_a, o_dm_b, o_dm_hi_in, o_dm_lo_in);
            stub_wr   <= 1'b1;
            stub_busy <= 1'b0;
          end
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [31:0] hi, input logic [31:0] lo, input logic err);
    exp_q.push_back('{kind: kind, hi: hi, lo: lo, err: err});
  endtask

  task automatic take(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, hi: 32'd0, lo: 32'd0, err: 1'b0};
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_unexpected: got event kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk("sb_kind", 64'(kind), 64'(e.kind));
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: pops the scoreboard on every commit, MF read and abort the DUT presents.
  exp_t mon_e;
  exp_t mon_ab;
  bit   mon_ok;
  logic mon_wr_prev = 1'b0;
  logic mon_pend    = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_wr_prev = 1'b0;
        mon_pend    = 1'b0;
      end else begin
        if (mon_pend) begin
          chk("abort_clear_1cyc", 64'(o_dm_clear), 64'd0);
          chk("abort_err", 64'(o_err_timeout), 64'(mon_ab.err));
          chk("abort_hi", 64'(o_hi), 64'(mon_ab.hi));
          chk("abort_lo", 64'(o_lo), 64'(mon_ab.lo));
          chk("abort_ready", 64'(o_op_ready), 64'd1);
          chk("abort_ctl", 64'({o_dm_mul, o_dm_div}), 64'd0);
          mon_pend = 1'b0;
        end
        if (mon_wr_prev) begin
          take(K_COMMIT, mon_e, mon_ok);
          if (mon_ok) begin
            chk("commit_hi", 64'(o_hi), 64'(mon_e.hi));
            chk("commit_lo", 64'(o_lo), 64'(mon_e.lo));
            chk("commit_ready", 64'(o_op_ready), 64'd1);
            chk("commit_ctl", 64'({o_dm_mul, o_dm_div, o_dm_add, o_dm_sub}), 64'd0);
          end
        end
        if (o_mf_valid) begin
          take(K_MF, mon_e, mon_ok);
          if (mon_ok) chk("mf_data", 64'(o_mf_data), 64'(mon_e.hi));
        end
        if (o_dm_clear) begin
          take(K_ABORT, mon_e, mon_ok);
          if (mon_ok) begin
            chk("clear_hi_kept", 64'(o_hi), 64'(mon_e.hi));
            chk("clear_lo_kept", 64'(o_lo), 64'(mon_e.lo));
            mon_ab   = mon_e;
            mon_pend = 1'b1;
          end
        end
        mon_wr_prev = stub_wr;
      end
    end
  end

  // Present an op from posedge+1 until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int bud;
    op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
    bud = 0;
    do begin
      @(negedge clk);
      bud++;
    end while (!o_op_ready && bud < 300);
    if (!o_op_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_accept: got op_ready 0 expected 1 within 300 cycles");
    end
    @(posedge clk); #1;
    op_valid = 1'b0; op_code = 4'd0;
  endtask

  task automatic wait_idle();
    int bud;
    bud = 0;
    do begin
      @(negedge clk);
      bud++;
    end while (!o_op_ready && bud < 300);
    chk("wait_idle", 64'(o_op_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish by 500us");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "bench timed out");
  end

  initial begin
    int cnt;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(o_op_ready), 64'd1);
    chk("rst_hilo", {o_hi, o_lo}, 64'd0);
    chk("rst_err_mf", 64'({o_err_timeout, o_mf_valid, o_dm_clear, o_dm_hold_result}), 64'd0);
    chk("rst_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub}), 64'd0);
    chk("rst_ops", {o_dm_a, o_dm_b}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // MULT -3 * 5
    push_exp(K_COMMIT, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    send(4'd1, 32'hFFFFFFFD, 32'd5);
    @(negedge clk);
    chk("mult_run_ready", 64'(o_op_ready), 64'd0);
    chk("mult_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub}), 64'b10100);
    chk("mult_ops", {o_dm_a, o_dm_b}, {32'hFFFFFFFD, 32'd5});
    @(posedge clk); #1;
    wait_idle();

    // DIV 7 / -2, then DIVU 100 / 7 back to back
    push_exp(K_COMMIT, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    send(4'd3, 32'd7, 32'hFFFFFFFE);
    @(negedge clk);
    chk("div_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub}), 64'b01100);
    @(posedge clk); #1;
    push_exp(K_COMMIT, 32'd2, 32'd14, 1'b0);
    send(4'd4, 32'd100, 32'd7);
    wait_idle();

    // MT then immediate MF, then MADDU
    push_exp(K_MF, 32'hFFFFFFFF, 32'd0, 1'b0);
    push_exp(K_MF, 32'h00000000, 32'd0, 1'b0);
    send(4'd9, 32'd0, 32'd0);
    send(4'd10, 32'hFFFFFFFF, 32'd0);
    send(4'd12, 32'd0, 32'd0);
    send(4'd11, 32'd0, 32'd0);
    push_exp(K_COMMIT, 32'd1, 32'd0, 1'b0);
    send(4'd6, 32'd1, 32'd1);
    @(negedge clk);
    chk("maddu_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub}), 64'b10010);
    chk("maddu_hilo_in", {o_dm_hi_in, o_dm_lo_in}, {32'd0, 32'hFFFFFFFF});
    @(posedge clk); #1;
    wait_idle();

    // MSUB 2*3 from {hi,lo} = 1
    send(4'd9, 32'd0, 32'd0);
    send(4'd10, 32'd1, 32'd0);
    push_exp(K_COMMIT, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b0);
    send(4'd7, 32'd2, 32'd3);
    @(negedge clk);
    chk("msub_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign, o_dm_add, o_dm_sub}), 64'b10101);
    @(posedge clk); #1;
    wait_idle();

    // MFLO held during RUN: stall until commit, then valid in the first IDLE cycle
    push_exp(K_COMMIT, 32'd1, 32'd0, 1'b0);
    push_exp(K_MF, 32'd0, 32'd0, 1'b0);
    send(4'd1, 32'h00010000, 32'h00010000);
    op_valid = 1'b1; op_code = 4'd12;
    repeat (3) begin
      @(negedge clk);
      chk("mf_run_stall", 64'({o_stall, o_mf_valid}), 64'b10);
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!o_op_ready && cnt < 100);
    chk("mf_after_commit", 64'({o_op_ready, o_stall, o_mf_valid}), 64'b101);
    @(posedge clk); #1 op_valid = 1'b0; op_code = 4'd0;

    // Flush ten cycles into a long DIV
    stub_lat = 40;
    push_exp(K_ABORT, 32'd1, 32'd0, 1'b0);
    send(4'd3, 32'h80000000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("pre_flush_clear", 64'(o_dm_clear), 64'd0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    stub_lat = 6;
    push_exp(K_COMMIT, 32'd0, 32'd42, 1'b0);
    send(4'd2, 32'd6, 32'd7);
    wait_idle();

    // Watchdog: stub never answers
    stub_en = 1'b0;
    push_exp(K_ABORT, 32'd0, 32'd42, 1'b1);
    send(4'd1, 32'd2, 32'd2);
    cnt = 0;
    do begin
      @(negedge clk);
      if (!o_op_ready) cnt++;
    end while (!o_op_ready && cnt < 200);
    chk("timeout_run_cycles", 64'(cnt), 64'(TIMEOUT));
    stub_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("timeout_sticky", 64'(o_err_timeout), 64'd1);
    @(posedge clk); #1;

    // Flush in IDLE discards an MTHI
    flush = 1'b1;
    send(4'd9, 32'h12345678, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_mthi", 64'(o_hi), 64'd0);
    @(posedge clk); #1;

    // Async reset mid-RUN
    send(4'd1, 32'd3, 32'd3);
    @(negedge clk);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    chk("arst_ready", 64'(o_op_ready), 64'd1);
    chk("arst_hilo", {o_hi, o_lo}, 64'd0);
    chk("arst_err", 64'({o_err_timeout, o_dm_clear}), 64'd0);
    chk("arst_ctl", 64'({o_dm_mul, o_dm_div, o_dm_using_sign}), 64'd0);
    chk("arst_ops", {o_dm_a, o_dm_b}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    push_exp(K_COMMIT, 32'd0, 32'd42, 1'b0);
    send(4'd2, 32'd6, 32'd7);
    wait_idle();
    repeat (2) @(posedge clk);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
